// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register file with scoreboard.
// Holds the default geometry used by reg_file_sb and reg_scoreboard.
package reg_file_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_RD     = 2;

  typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending bit per architectural register.
// Issue sets a bit, writeback clears it, flush clears everything.
// Issue wins over a same-cycle writeback to the same register; flush drops issues.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iss_en,
  input  logic [ADDR_WIDTH-1:0]    iss_addr,
  input  logic                     clr_en,
  input  logic [ADDR_WIDTH-1:0]    clr_addr,
  input  logic                     flush,
  output logic [2**ADDR_WIDTH-1:0] busy,
  output logic                     iss_ready
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             iss_accept;

  // Readiness looks only at the pre-edge state: no writeback forwarding.
  assign iss_ready  = !busy_q[iss_addr] || ((ZERO_REG != 0) && (iss_addr == '0));
  assign iss_accept = iss_en && iss_ready && !flush;
  assign busy       = busy_q;

  // Next busy state: flush clears all, otherwise clear on writeback then set on issue.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en)     busy_d[clr_addr] = 1'b0;
      if (iss_accept) busy_d[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Busy-bit state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with combinational read ports and an issue/writeback scoreboard.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle writeback
// data to matching read ports (and report them not busy in that cycle).
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic                         iss_ready,
  input  logic                         flush
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  wr_store;

  // Writes to register 0 are discarded when it is hardwired to zero.
  assign wr_store = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Next register contents: a single writeback port.
  always_comb begin
    regs_d = regs_q;
    if (wr_store) regs_d[wr_addr] = wr_data;
  end

  // Register array storage, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .clr_en    (wr_en),
    .clr_addr  (wr_addr),
    .flush     (flush),
    .busy      (busy),
    .iss_ready (iss_ready)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  is_zero;

    assign addr    = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);

`ifdef REG_FILE_BYPASS_EN
    logic hit;
    // Forward the in-flight writeback; register 0 never forwards.
    assign hit = wr_en && (wr_addr == addr) && !is_zero;
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
      is_zero ? '0 : (hit ? wr_data : regs_q[addr]);
    assign rd_busy[k] = !is_zero && !hit && busy[addr];
`else
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = is_zero ? '0 : regs_q[addr];
    assign rd_busy[k] = !is_zero && busy[addr];
`endif
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, as the register width in bits.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 5, so that depth = 2**ADDR_WIDTH registers.
REQ-003 The block SHALL take parameter NUM_RD, default 2, as the number of combinational read ports (1..4).
REQ-004 The block SHALL take parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero and never busy.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port rd_addr, input, NUM_RD*ADDR_WIDTH bits: packed read addresses, port k at slice k.
REQ-008 The block SHALL have port rd_data, output, NUM_RD*DATA_WIDTH bits: packed combinational read data.
REQ-009 The block SHALL have port rd_busy, output, NUM_RD bits: scoreboard pending bit per read port.
REQ-010 The block SHALL have ports wr_en (1 bit), wr_addr (ADDR_WIDTH bits) and wr_data (DATA_WIDTH bits), inputs: the writeback port.
REQ-011 The block SHALL have ports iss_en (1 bit) and iss_addr (ADDR_WIDTH bits), inputs: an issue request marking a destination pending.
REQ-012 The block SHALL have port iss_ready, output, 1 bit, high when iss_addr is not busy or is register 0 with ZERO_REG=1.
REQ-013 The block SHALL have port flush, input, 1 bit, a synchronous clear of all busy bits.

Function
REQ-014 Reads SHALL be combinational: rd_data[k] = regs[rd_addr[k]], and 0 for address 0 when ZERO_REG=1.
REQ-015 Each rd_busy[k] SHALL equal busy[rd_addr[k]] combinationally.
REQ-016 When wr_en is high, regs[wr_addr] SHALL take wr_data at the clock edge, ignoring address 0 when ZERO_REG=1.
REQ-017 When wr_en is high, busy[wr_addr] SHALL clear at the same edge.
REQ-018 An issue SHALL be accepted only when iss_en and iss_ready are both high; it then sets busy[iss_addr] at the edge.
REQ-019 iss_en with iss_ready low SHALL be ignored, leaving busy unchanged, and the caller retries.
REQ-020 Simultaneous writeback and accepted issue to the same address SHALL store the data and leave busy set (issue wins).
REQ-021 iss_ready SHALL be computed from the pre-edge busy state, with no same-cycle writeback forwarding.
REQ-022 flush SHALL clear every busy bit at the edge, drop any same-cycle issue, and still perform a same-cycle write.
REQ-023 Writes SHALL have 1-cycle latency: new data is visible on rd_data in the cycle after the write edge, unless bypass is enabled.

Reset
REQ-024 While rst_n is low, all registers SHALL be 0 and all busy bits 0, asynchronously.
REQ-025 On reset, outputs SHALL be rd_data all 0, rd_busy all 0, and iss_ready 1.
REQ-026 Reset asserted mid-operation SHALL abort any pending write or issue, with no partial update.

Configuration
REQ-027 With macro REG_FILE_BYPASS_EN defined, a read port whose address equals wr_addr while wr_en is high SHALL return wr_data, and its rd_busy SHALL read 0 in that cycle.
REQ-028 The bypass in REQ-027 SHALL exclude register 0 when ZERO_REG=1.
REQ-029 Without REG_FILE_BYPASS_EN, reads SHALL return the stored value and stored busy bit only.

Structure
REQ-030 The shared package reg_file_pkg SHALL hold the default DATA_WIDTH, ADDR_WIDTH and NUM_RD constants, plus the typedefs reg_addr_t and reg_data_t.
REQ-031 The busy-bit array, together with its issue, clear and flush logic, SHALL be the sub-module reg_scoreboard, instantiated once.
REQ-032 Read ports SHALL be built with a generate loop over NUM_RD.

Verification
REQ-033 Reset check: after rst_n is released, rd_addr={5,0} SHALL give rd_data 0, rd_busy=00 and iss_ready=1.
REQ-034 Issue then writeback: iss_en, iss_addr=7 -> rd_busy=1 for x7 next cycle; then wr_en to x7 with 0xDEADBEEF -> next cycle rd_data=0xDEADBEEF and busy=0.
REQ-035 Double issue: issue x3, then iss_en to x3 -> iss_ready=0 and busy stays 1; after writeback to x3, iss_ready=1.
REQ-036 Same-cycle issue and write to x9 with 0x1234 -> x9 reads 0x1234 and rd_busy stays 1.
REQ-037 Bypass: wr_en to x4 with 0xA5A5A5A5 while rd_addr=4 -> rd_data=0xA5A5A5A5 in the same cycle with REG_FILE_BYPASS_EN, and the old value without it.
REQ-038 Zero register: with ZERO_REG=1, a write of 0xFFFFFFFF to x0 and an issue to x0 -> x0 reads 0, rd_busy=0 and iss_ready=1.
